poly1305_mac_engine: RTL and testbench

- Parametrised Poly1305 one-time authenticator for the ChaCha20-Poly1305 AEAD datapath.
- Accepts a 256-bit one-time key (r‖s), absorbs 128-bit message blocks (last block may be partial), and produces the 128-bit tag.
- Compares the tag against an expected tag to raise `tag_ok`.
- Compared with the monolithic core, adds a configurable digit-serial multiplier (area/latency trade), partial-block padding, abort, and a built-in cycle counter replacing bench-side instrumentation.

---
 rtl/poly1305_pkg.sv | 35 +++
 rtl/poly1305_mac_engine_digit_mul.sv | 34 +++
 rtl/poly1305_mac_engine.sv | 191 +++++++++++++++++++
 tb/tb_poly1305_mac_engine.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly1305_pkg.sv
// Shared types, constants and block padding for the Poly1305 MAC engine.
package poly1305_pkg;

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned ACC_W  = 131;
  localparam int unsigned PROD_W = 259;

  localparam logic [ACC_W-1:0] P130       = 131'h3_ffff_ffff_ffff_ffff_ffff_ffff_ffff_fffb;
  localparam logic [BLK_W-1:0] CLAMP_MASK = 128'h0fff_fffc_0fff_fffc_0fff_fffc_0fff_ffff;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BLK,
    S_MUL,
    S_RED1,
    S_RED2,
    S_FINAL,
    S_DONE
  } state_e;

  function automatic logic bytes_bad(input logic [4:0] nbytes);
    return (nbytes == 5'd0) || (nbytes > 5'd16);
  endfunction

  // Keep the low k bytes and append the 2^(8k) marker; illegal counts pad as a full block.
  function automatic logic [ACC_W-1:0] pad_block(input logic [BLK_W-1:0] data,
                                                 input logic [4:0]       nbytes);
    logic [7:0]       nbits;
    logic [ACC_W-1:0] hibit;
    nbits = bytes_bad(nbytes) ? 8'd128 : {nbytes, 3'b000};
    hibit = ACC_W'(1) << nbits;
    return (ACC_W'(data) & (hibit - ACC_W'(1))) | hibit;
  endfunction

endpackage

// File: rtl/poly1305_mac_engine_digit_mul.sv
// Digit-serial multiplier: accumulates a * r_digit shifted into digit position each step.
module poly1305_digit_mul
  import poly1305_pkg::*;
#(
  parameter int unsigned DIGIT_W = 32,
  parameter int unsigned IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               step_i,
  input  logic [ACC_W-1:0]   a_i,
  input  logic [DIGIT_W-1:0] r_digit_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [PROD_W-1:0]  prod_o
);

  logic [PROD_W-1:0] prod_q, prod_d, partial;

  always_comb begin
    partial = (PROD_W'(a_i) * PROD_W'(r_digit_i)) << (DIGIT_W * 32'(idx_i));
    prod_d  = prod_q;
    if (clear_i)     prod_d = '0;
    else if (step_i) prod_d = prod_q + partial;
  end

  always_ff @(posedge clk) begin
    if (!rst) prod_q <= '0;
    else      prod_q <= prod_d;
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/poly1305_mac_engine.sv
// Poly1305 one-time authenticator: block absorb, digit-serial multiply, two-step reduction, tag compare.
module poly1305_mac_engine
  import poly1305_pkg::*;
#(
  parameter int unsigned DIGIT_W = 32,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [255:0]     key_in,
  input  logic             abort,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [BLK_W-1:0] blk_data,
  input  logic [4:0]       blk_bytes,
  input  logic             blk_last,
  input  logic [BLK_W-1:0] exp_tag,
  output logic             busy,
  output logic             tag_valid,
  output logic [BLK_W-1:0] tag,
  output logic             tag_ok,
  output logic             err,
  output logic [CNT_W-1:0] perf_cycles
);

  localparam int unsigned N_MUL = BLK_W / DIGIT_W;
  localparam int unsigned IDX_W = (N_MUL > 1) ? $clog2(N_MUL) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_MUL - 1);

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   r_q, r_d, s_q, s_d, tag_q, tag_d;
  logic [ACC_W-1:0]   h_q, h_d, a_q, a_d, t_q, t_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   perf_q, perf_d;
  logic               last_q, last_d, err_q, err_d, tag_ok_q, tag_ok_d;
  logic               busy_q, busy_d, ready_q, ready_d, tag_valid_q, tag_valid_d;
  logic               mul_clear_c, mul_step_c;
  logic [DIGIT_W-1:0] r_digit_c;
  logic [PROD_W-1:0]  prod_c;
  logic [ACC_W-1:0]   fold_c, final_c;
  logic [BLK_W-1:0]   tag_c;

  assign mul_step_c = (state_q == S_MUL);
  assign r_digit_c  = DIGIT_W'(r_q >> (DIGIT_W * 32'(idx_q)));

  poly1305_digit_mul #(
    .DIGIT_W(DIGIT_W),
    .IDX_W  (IDX_W)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (mul_clear_c),
    .step_i   (mul_step_c),
    .a_i      (a_q),
    .r_digit_i(r_digit_c),
    .idx_i    (idx_q),
    .prod_o   (prod_c)
  );

  // Full reduction of the partially reduced accumulator before adding s.
  assign fold_c  = ACC_W'(h_q[129:0]) + ACC_W'(h_q[130]) * ACC_W'(5);
  assign final_c = (fold_c >= P130) ? (fold_c - P130) : fold_c;
  assign tag_c   = BLK_W'(final_c + ACC_W'(s_q));

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    s_d         = s_q;
    h_d         = h_q;
    a_d         = a_q;
    t_d         = t_q;
    idx_d       = idx_q;
    last_d      = last_q;
    tag_d       = tag_q;
    tag_ok_d    = tag_ok_q;
    err_d       = err_q;
    perf_d      = perf_q;
    tag_valid_d = 1'b0;
    mul_clear_c = 1'b0;

    if (state_q != S_IDLE && state_q != S_DONE) perf_d = perf_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_WAIT_BLK;
          r_d      = key_in[127:0] & CLAMP_MASK;
          s_d      = key_in[255:128];
          h_d      = '0;
          tag_d    = '0;
          tag_ok_d = 1'b0;
          err_d    = 1'b0;
          perf_d   = CNT_W'(1);
        end
      end
      S_WAIT_BLK: begin
        if (blk_valid) begin
          state_d     = S_MUL;
          a_d         = h_q + pad_block(blk_data, blk_bytes);
          err_d       = err_q | bytes_bad(blk_bytes);
          last_d      = blk_last;
          idx_d       = '0;
          mul_clear_c = 1'b1;
        end
      end
      S_MUL: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) state_d = S_RED1;
      end
      S_RED1: begin
        t_d     = ACC_W'(prod_c[129:0]) + ACC_W'(prod_c[PROD_W-1:130]) * ACC_W'(5);
        state_d = S_RED2;
      end
      S_RED2: begin
        h_d     = ACC_W'(t_q[129:0]) + ACC_W'(t_q[130]) * ACC_W'(5);
        state_d = last_q ? S_FINAL : S_WAIT_BLK;
      end
      S_FINAL: begin
        tag_d       = tag_c;
        tag_ok_d    = (tag_c == exp_tag);
        tag_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything; results from the previous message stay visible.
    if (abort) begin
      state_d     = S_IDLE;
      r_d         = r_q;
      s_d         = s_q;
      h_d         = '0;
      tag_d       = tag_q;
      tag_ok_d    = tag_ok_q;
      err_d       = err_q;
      perf_d      = perf_q;
      tag_valid_d = 1'b0;
      mul_clear_c = 1'b0;
    end

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_WAIT_BLK);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      s_q         <= '0;
      h_q         <= '0;
      a_q         <= '0;
      t_q         <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
      tag_q       <= '0;
      tag_ok_q    <= 1'b0;
      err_q       <= 1'b0;
      perf_q      <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      tag_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      s_q         <= s_d;
      h_q         <= h_d;
      a_q         <= a_d;
      t_q         <= t_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      tag_q       <= tag_d;
      tag_ok_q    <= tag_ok_d;
      err_q       <= err_d;
      perf_q      <= perf_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      tag_valid_q <= tag_valid_d;
    end
  end

  assign blk_ready   = ready_q;
  assign busy        = busy_q;
  assign tag_valid   = tag_valid_q;
  assign tag         = tag_q;
  assign tag_ok      = tag_ok_q;
  assign err         = err_q;
  assign perf_cycles = perf_q;

endmodule

// File: tb/tb_poly1305_mac_engine.sv
// Bench for poly1305_mac_engine: three digit widths, RFC vector, edge cases and random messages vs. a modular-arithmetic model.
module tb_poly1305_mac_engine;

  localparam logic [255:0] RFC_KEY = 256'h1bf54941aff6bf4afdb20dfb8a800301_a806d542fe52447f336d555778bed685;
  localparam logic [127:0] RFC_TAG = 128'ha927010caf8b2bc2c6365130c11d06a8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [2:0]   start_v = '0, blk_valid_v = '0;
  logic [255:0] key_in = '0;
  logic         abort = 1'b0;
  logic [127:0] blk_data = '0, exp_tag = '0;
  logic [4:0]   blk_bytes = '0;
  logic         blk_last = 1'b0;
  logic [2:0]   blk_ready_v, busy_v, tag_valid_v, tag_ok_v, err_v;
  logic [127:0] tag_v [3];
  logic [31:0]  perf_v [3];

  int tests = 0, failed = 0, cyc = 0;
  logic [127:0] md [8];
  logic [4:0]   mb [8];
  int           mn;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    poly1305_mac_engine #(
      .DIGIT_W(g == 0 ? 32 : (g == 1 ? 8 : 128)),
      .CNT_W  (32)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start_v[g]),
      .key_in     (key_in),
      .abort      (abort),
      .blk_valid  (blk_valid_v[g]),
      .blk_ready  (blk_ready_v[g]),
      .blk_data   (blk_data),
      .blk_bytes  (blk_bytes),
      .blk_last   (blk_last),
      .exp_tag    (exp_tag),
      .busy       (busy_v[g]),
      .tag_valid  (tag_valid_v[g]),
      .tag        (tag_v[g]),
      .tag_ok     (tag_ok_v[g]),
      .err        (err_v[g]),
      .perf_cycles(perf_v[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nmul(input int sel);
    return (sel == 0) ? 4 : ((sel == 1) ? 16 : 1);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: h = ((h + m) * r) mod (2^130 - 5); tag = (h + s) mod 2^128.
  function automatic logic [127:0] model_tag(input logic [255:0] key);
    logic [259:0] p, r, h, m, one;
    int k;
    one = 260'd1;
    p   = (one << 130) - 260'd5;
    r   = 260'(key[127:0] & 128'h0ffffffc0ffffffc0ffffffc0fffffff);
    h   = '0;
    for (int b = 0; b < mn; b++) begin
      k = int'(mb[b]);
      if (k == 0 || k > 16) k = 16;
      m = (260'(md[b]) & ((one << (8 * k)) - one)) + (one << (8 * k));
      h = ((h + m) * r) % p;
    end
    return 128'(h + 260'(key[255:128]));
  endfunction

  task automatic set_rfc_msg();
    md[0] = 128'h6f4620636968706172676f7470797243; mb[0] = 5'd16;
    md[1] = 128'h6f7247206863726165736552206d7572; mb[1] = 5'd16;
    md[2] = 128'h00000000000000000000000000007075; mb[2] = 5'd2;
    mn = 3;
  endtask

  // Drives one message on instance sel; checks handshake latency, tag_valid pulse and perf_cycles.
  task automatic run_msg(input int sel, input logic [255:0] key, input logic [127:0] exp,
                         input bit poke_start, output logic [127:0] tag_o,
                         output logic ok_o, output logic err_o);
    int s_cyc, acc, prev, n, w;
    n = nmul(sel);
    tag_o = '0; ok_o = 1'b0; err_o = 1'b0;
    key_in = key; exp_tag = exp;
    start_v[sel] = 1'b1; tick(); start_v[sel] = 1'b0;
    s_cyc = cyc;
    if (poke_start) begin
      key_in = ~key; start_v[sel] = 1'b1; tick(); start_v[sel] = 1'b0; key_in = key;
    end
    prev = -1;
    acc  = cyc;
    for (int b = 0; b < mn; b++) begin
      w = 0;
      while (blk_ready_v[sel] !== 1'b1 && w < 100) begin tick(); w++; end
      if (w >= 100) begin
        tests++; failed++;
        $display("FAIL ready_timeout: inst %0d block %0d never saw blk_ready", sel, b);
        return;
      end
      blk_valid_v[sel] = 1'b1; blk_data = md[b]; blk_bytes = mb[b]; blk_last = (b == mn - 1);
      tick();
      blk_valid_v[sel] = 1'b0; blk_last = 1'b0;
      acc = cyc;
      if (prev >= 0) begin
        tests++;
        if (acc - prev !== n + 3) begin
          failed++; $display("FAIL ready_gap: inst %0d got %0d cycles want %0d", sel, acc - prev, n + 3);
        end
      end
      prev = acc;
      tests++;
      if (blk_ready_v[sel] !== 1'b0 || busy_v[sel] !== 1'b1) begin
        failed++; $display("FAIL accept_state: inst %0d ready=%b busy=%b want 0/1", sel, blk_ready_v[sel], busy_v[sel]);
      end
    end
    w = 0;
    while (tag_valid_v[sel] !== 1'b1 && w < 100) begin tick(); w++; end
    if (w >= 100) begin
      tests++; failed++;
      $display("FAIL tag_timeout: inst %0d tag_valid never seen", sel);
      return;
    end
    tests++;
    if (cyc - acc !== n + 3) begin
      failed++; $display("FAIL tag_latency: inst %0d got %0d want %0d", sel, cyc - acc + 1, n + 4);
    end
    tests++;
    if (perf_v[sel] !== 32'(cyc + 1 - s_cyc)) begin
      failed++; $display("FAIL perf_cycles: inst %0d got %0d want %0d", sel, perf_v[sel], cyc + 1 - s_cyc);
    end
    tag_o = tag_v[sel]; ok_o = tag_ok_v[sel]; err_o = err_v[sel];
    tick();
    tests++;
    if (tag_valid_v[sel] !== 1'b0 || busy_v[sel] !== 1'b0 || perf_v[sel] !== 32'(cyc - s_cyc)) begin
      failed++;
      $display("FAIL done_exit: inst %0d tag_valid=%b busy=%b perf=%0d want 0/0/%0d",
               sel, tag_valid_v[sel], busy_v[sel], perf_v[sel], cyc - s_cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({blk_ready_v[i], busy_v[i], tag_valid_v[i], tag_ok_v[i], err_v[i]} !== 5'b0 ||
          tag_v[i] !== '0 || perf_v[i] !== '0) begin
        failed++;
        $display("FAIL reset_outputs: inst %0d ctl=%b tag=%h perf=%0d want all 0", i,
                 {blk_ready_v[i], busy_v[i], tag_valid_v[i], tag_ok_v[i], err_v[i]}, tag_v[i], perf_v[i]);
      end
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_rfc_widths();
    logic [127:0] t; logic ok, e;
    for (int sel = 0; sel < 3; sel++) begin
      set_rfc_msg();
      run_msg(sel, RFC_KEY, RFC_TAG, 1'b0, t, ok, e);
      tests++;
      if (t !== RFC_TAG || ok !== 1'b1 || e !== 1'b0) begin
        failed++; $display("FAIL rfc_tag: inst %0d got %h ok=%b err=%b want %h ok=1 err=0", sel, t, ok, e, RFC_TAG);
      end
    end
  endtask

  task automatic test_zero_r();
    logic [127:0] t, s; logic ok, e;
    s = 128'h000102030405060708090a0b0c0d0e0f;
    md[0] = rnd128(); mb[0] = 5'($urandom_range(1, 16)); mn = 1;
    run_msg(0, {s, 128'h0}, s ^ 128'h1, 1'b0, t, ok, e);
    tests++;
    if (t !== s || ok !== 1'b0 || e !== 1'b0) begin
      failed++; $display("FAIL zero_r: got %h ok=%b err=%b want %h ok=0 err=0", t, ok, e, s);
    end
  endtask

  task automatic test_illegal_len();
    logic [127:0] t, s; logic ok, e;
    s = rnd128();
    md[0] = '1; mb[0] = 5'd0; mn = 1;
    run_msg(0, {s, 128'h1}, s - 128'd1, 1'b0, t, ok, e);
    tests++;
    if (t !== s - 128'd1 || ok !== 1'b1 || e !== 1'b1) begin
      failed++; $display("FAIL illegal_len: got %h ok=%b err=%b want %h ok=1 err=1", t, ok, e, s - 128'd1);
    end
    start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
    tests++;
    if (err_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
      failed++; $display("FAIL err_clear: err=%b busy=%b want 0/1", err_v[0], busy_v[0]);
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_abort();
    logic [127:0] t; logic ok, e; int s_cyc, w;
    set_rfc_msg();
    key_in = RFC_KEY; start_v[0] = 1'b1; tick(); start_v[0] = 1'b0; s_cyc = cyc;
    w = 0;
    while (blk_ready_v[0] !== 1'b1 && w < 20) begin tick(); w++; end
    blk_valid_v[0] = 1'b1; blk_data = md[0]; blk_bytes = mb[0]; tick(); blk_valid_v[0] = 1'b0;
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    tests++;
    if (busy_v[0] !== 1'b0 || blk_ready_v[0] !== 1'b0 || perf_v[0] !== 32'(cyc - s_cyc)) begin
      failed++; $display("FAIL abort_mul: busy=%b ready=%b perf=%0d want 0/0/%0d", busy_v[0], blk_ready_v[0], perf_v[0], cyc - s_cyc);
    end
    start_v[0] = 1'b1; abort = 1'b1; tick(); start_v[0] = 1'b0; abort = 1'b0;
    tests++;
    if (busy_v[0] !== 1'b0) begin
      failed++; $display("FAIL abort_start: busy=%b want 0", busy_v[0]);
    end
    run_msg(0, RFC_KEY, RFC_TAG, 1'b0, t, ok, e);
    tests++;
    if (t !== RFC_TAG || ok !== 1'b1) begin
      failed++; $display("FAIL abort_recover: got %h ok=%b want %h ok=1", t, ok, RFC_TAG);
    end
  endtask

  task automatic test_start_in_wait();
    logic [127:0] t; logic ok, e;
    set_rfc_msg();
    run_msg(0, RFC_KEY, RFC_TAG, 1'b1, t, ok, e);
    tests++;
    if (t !== RFC_TAG || ok !== 1'b1) begin
      failed++; $display("FAIL start_ignored: got %h ok=%b want %h ok=1", t, ok, RFC_TAG);
    end
  endtask

  task automatic test_reset_midop();
    int acc, w;
    key_in = {rnd128(), rnd128()};
    start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
    w = 0;
    while (blk_ready_v[0] !== 1'b1 && w < 20) begin tick(); w++; end
    blk_valid_v[0] = 1'b1; blk_data = rnd128(); blk_bytes = 5'd20; blk_last = 1'b1;
    tick();
    blk_valid_v[0] = 1'b0; blk_last = 1'b0; acc = cyc;
    while (cyc < acc + 4) tick();
    tests++;
    if (err_v[0] !== 1'b1 || busy_v[0] !== 1'b1) begin
      failed++; $display("FAIL pre_reset: err=%b busy=%b want 1/1", err_v[0], busy_v[0]);
    end
    rst = 1'b0; tick();
    tests++;
    if ({blk_ready_v[0], busy_v[0], tag_valid_v[0], tag_ok_v[0], err_v[0]} !== 5'b0 ||
        tag_v[0] !== '0 || perf_v[0] !== '0) begin
      failed++; $display("FAIL reset_red1: ctl=%b tag=%h perf=%0d want all 0",
                         {blk_ready_v[0], busy_v[0], tag_valid_v[0], tag_ok_v[0], err_v[0]}, tag_v[0], perf_v[0]);
    end
    rst = 1'b1; tick();
  endtask

  task automatic test_random();
    logic [255:0] key; logic [127:0] t, want, exp; logic ok, e; int sel;
    for (int it = 0; it < 15; it++) begin
      sel = $urandom_range(0, 2);
      key = {rnd128(), rnd128()};
      mn  = $urandom_range(1, 4);
      for (int b = 0; b < mn; b++) begin
        md[b] = rnd128();
        mb[b] = (b == mn - 1) ? 5'($urandom_range(1, 16)) : 5'd16;
      end
      want = model_tag(key);
      exp  = ($urandom_range(0, 1) == 1) ? want : rnd128();
      run_msg(sel, key, exp, 1'b0, t, ok, e);
      tests++;
      if (t !== want || ok !== (exp == want) || e !== 1'b0) begin
        failed++; $display("FAIL random_tag: it %0d inst %0d got %h ok=%b err=%b want %h ok=%b err=0",
                           it, sel, t, ok, e, want, exp == want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rfc_widths();
    test_zero_r();
    test_illegal_len();
    test_abort();
    test_start_in_wait();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
